// File: rtl/run_controller_pkg.sv
// Shared types for the processor run controller: FSM states and end-of-run
// status codes.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_STEP    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

endpackage

// File: rtl/run_controller_if.sv
// Control/status bundle between a run requester (master) and the run
// controller (slave).
interface run_controller_if #(
  parameter int CNT_W  = 16,
  parameter int STEP_W = 8
) ();
  logic              start;
  logic              mode;
  logic [STEP_W-1:0] step_cnt;
  logic              abort;
  logic              halt;
  logic              core_rst;
  logic              core_en;
  logic              busy;
  logic              done;
  logic [1:0]        status;
  logic [CNT_W-1:0]  cycles;

  modport master (
    output start, mode, step_cnt, abort, halt,
    input  core_rst, core_en, busy, done, status, cycles
  );

  modport slave (
    input  start, mode, step_cnt, abort, halt,
    output core_rst, core_en, busy, done, status, cycles
  );
endinterface

// File: rtl/run_controller_reset_sync.sv
// Active-low reset synchronizer: asserts asynchronously, releases after two
// clock edges so downstream flops never see a release near the clock edge.
module reset_sync (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n
);
  logic meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta  <= 1'b0;
      rst_n <= 1'b0;
    end else begin
      meta  <= 1'b1;
      rst_n <= meta;
    end
  end
endmodule

// File: rtl/run_controller.sv
// Sequences processor reset and execution: reset hold, enabled run with
// watchdog, halt/abort/step termination and an enabled-cycle counter.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 80,
  parameter int STEP_W     = 8
) (
  input logic             clk,
  input logic             reset,
  run_controller_if.slave bus
);

  localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES - 1);

  logic              rst_n;
  state_t            state;
  logic [7:0]        hold;
  logic              step_mode;
  logic [STEP_W-1:0] step_lat;
  logic              core_rst_q;
  logic              core_en_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        status_q;
  logic [CNT_W-1:0]  cycles_q;

  reset_sync u_rsync (
    .clk    (clk),
    .arst_n (reset),
    .rst_n  (rst_n)
  );

  // One extra bit so the compare against the budget still works once the
  // counter has saturated.
  logic [CNT_W:0]   cnt_nxt;
  logic [CNT_W:0]   step_ext;
  logic [CNT_W-1:0] cyc_inc;
  logic             hit_max;
  logic             hit_step;
  logic             run_exit;
  logic [1:0]       exit_code;

  assign cnt_nxt  = {1'b0, cycles_q} + (CNT_W+1)'(1);
  assign step_ext = (CNT_W+1)'(step_lat);
  assign cyc_inc  = cnt_nxt[CNT_W] ? cycles_q : cnt_nxt[CNT_W-1:0];
  assign hit_max  = (MAX_CYCLES != 0) && (cnt_nxt == (CNT_W+1)'(MAX_CYCLES));
  assign hit_step = step_mode && (cnt_nxt == step_ext);

  always_comb begin
    run_exit  = 1'b1;
    exit_code = ST_ABORT;
    if (bus.abort)      exit_code = ST_ABORT;
    else if (bus.halt)  exit_code = ST_HALT;
    else if (hit_max)   exit_code = ST_TIMEOUT;
    else if (hit_step)  exit_code = ST_STEP;
    else                run_exit  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hold       <= '0;
      step_mode  <= 1'b0;
      step_lat   <= '0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= ST_STEP;
      cycles_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_RESET;
            hold       <= HOLD_INIT;
            step_mode  <= bus.mode;
            step_lat   <= (bus.step_cnt == '0) ? STEP_W'(1) : bus.step_cnt;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b1;
            cycles_q   <= '0;
          end
        end
        S_RESET: begin
          if (bus.abort) begin
            state      <= S_DONE;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            status_q   <= ST_ABORT;
          end else if (hold == 8'd0) begin
            state      <= S_RUN;
            core_rst_q <= 1'b0;
            core_en_q  <= 1'b1;
          end else begin
            hold <= hold - 8'd1;
          end
        end
        S_RUN: begin
          // The cycle that triggers the exit was enabled, so it is counted.
          cycles_q <= cyc_inc;
          if (run_exit) begin
            state     <= S_DONE;
            core_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            status_q  <= exit_code;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.core_rst = core_rst_q;
  assign bus.core_en  = core_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.status   = status_q;
  assign bus.cycles   = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed for RST_CYCLES=2, MAX_CYCLES=80.
module tb_run_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   en_cnt, rst_cnt;

  always #5 clk = ~clk;

  run_controller_if #(.CNT_W(16), .STEP_W(8)) bus ();

  run_controller #(
    .RST_CYCLES (2),
    .CNT_W      (16),
    .MAX_CYCLES (80),
    .STEP_W     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Pulses start for one edge; on return the block should be in RESET.
  task automatic start_run(input logic m, input logic [7:0] sc);
    bus.mode     = m;
    bus.step_cnt = sc;
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
  endtask

  // Counts RESET-hold and enabled samples until done, bounded.
  task automatic run_until_done(output int en, output int rs);
    int budget;
    en = 0;
    rs = 0;
    budget = 400;
    while (!bus.done && budget > 0) begin
      if (bus.core_en) en++;
      if (bus.core_rst && bus.busy) rs++;
      tick(1);
      budget--;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.step_cnt = 8'd0;
    bus.abort    = 1'b0;
    bus.halt     = 1'b0;

    // Power-on reset values
    tick(10);
    chk("rst_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("rst_core_en",  {31'd0, bus.core_en},  32'd0);
    chk("rst_busy",     {31'd0, bus.busy},     32'd0);
    chk("rst_done",     {31'd0, bus.done},     32'd0);
    chk("rst_status",   {30'd0, bus.status},   32'd0);
    chk("rst_cycles",   {16'd0, bus.cycles},   32'd0);

    // Free run to timeout
    reset = 1'b1;
    tick(4);
    start_run(1'b0, 8'd0);
    chk("free_in_reset", {31'd0, bus.core_rst}, 32'd1);
    run_until_done(en_cnt, rst_cnt);
    chk("free_rst_cnt", rst_cnt, 32'd2);
    chk("free_en_cnt",  en_cnt,  32'd80);
    chk("free_status",  {30'd0, bus.status}, 32'd2);
    chk("free_cycles",  {16'd0, bus.cycles}, 32'd80);
    chk("free_done_en", {31'd0, bus.core_en}, 32'd0);
    tick(1);
    chk("free_done_pulse", {31'd0, bus.done}, 32'd0);
    chk("free_hold_cyc",   {16'd0, bus.cycles}, 32'd80);

    // Abort in DONE is ignored
    bus.abort = 1'b1;
    tick(2);
    bus.abort = 1'b0;
    chk("done_abort_done",   {31'd0, bus.done},   32'd0);
    chk("done_abort_status", {30'd0, bus.status}, 32'd2);
    chk("done_abort_rst",    {31'd0, bus.core_rst}, 32'd0);

    // Halt after 20 enabled cycles
    start_run(1'b0, 8'd0);
    tick(2);
    chk("halt_run_en", {31'd0, bus.core_en}, 32'd1);
    chk("halt_run_cyc0", {16'd0, bus.cycles}, 32'd0);
    tick(20);
    chk("halt_pre_cyc", {16'd0, bus.cycles}, 32'd20);
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    chk("halt_done",   {31'd0, bus.done},    32'd1);
    chk("halt_en",     {31'd0, bus.core_en}, 32'd0);
    chk("halt_status", {30'd0, bus.status},  32'd1);
    chk("halt_cycles", {16'd0, bus.cycles},  32'd21);

    // Step mode, 3 cycles then 0 (treated as 1)
    start_run(1'b1, 8'd3);
    run_until_done(en_cnt, rst_cnt);
    chk("step3_en",     en_cnt, 32'd3);
    chk("step3_status", {30'd0, bus.status}, 32'd0);
    chk("step3_cycles", {16'd0, bus.cycles}, 32'd3);
    tick(1);
    start_run(1'b1, 8'd0);
    run_until_done(en_cnt, rst_cnt);
    chk("step0_en",     en_cnt, 32'd1);
    chk("step0_status", {30'd0, bus.status}, 32'd0);
    chk("step0_cycles", {16'd0, bus.cycles}, 32'd1);

    // Abort during RESET
    start_run(1'b0, 8'd0);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("abrst_done",   {31'd0, bus.done},     32'd1);
    chk("abrst_status", {30'd0, bus.status},   32'd3);
    chk("abrst_cycles", {16'd0, bus.cycles},   32'd0);
    chk("abrst_corerst", {31'd0, bus.core_rst}, 32'd0);

    // Abort on the 10th enabled cycle
    start_run(1'b0, 8'd0);
    tick(2 + 9);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("abrun_status", {30'd0, bus.status}, 32'd3);
    chk("abrun_cycles", {16'd0, bus.cycles}, 32'd10);

    // Abort beats halt
    start_run(1'b0, 8'd0);
    tick(2 + 5);
    bus.abort = 1'b1;
    bus.halt  = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    bus.halt  = 1'b0;
    chk("prio_status", {30'd0, bus.status}, 32'd3);
    chk("prio_cycles", {16'd0, bus.cycles}, 32'd6);

    // Start during RUN is ignored
    start_run(1'b0, 8'd0);
    tick(2 + 4);
    start_run(1'b1, 8'd1);
    chk("ign_busy",   {31'd0, bus.busy},    32'd1);
    chk("ign_en",     {31'd0, bus.core_en}, 32'd1);
    chk("ign_cycles", {16'd0, bus.cycles},  32'd5);
    run_until_done(en_cnt, rst_cnt);
    chk("ign_status",   {30'd0, bus.status}, 32'd2);
    chk("ign_fin_cyc",  {16'd0, bus.cycles}, 32'd80);

    // Mid-run reset at RUN cycle 30
    start_run(1'b0, 8'd0);
    tick(2 + 30);
    chk("mid_pre_cyc", {16'd0, bus.cycles}, 32'd30);
    reset = 1'b0;
    #1;
    chk("mid_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("mid_core_en",  {31'd0, bus.core_en},  32'd0);
    chk("mid_cycles",   {16'd0, bus.cycles},   32'd0);
    chk("mid_done",     {31'd0, bus.done},     32'd0);
    tick(3);
    chk("mid_no_done", {31'd0, bus.done}, 32'd0);

    // Release: start on the 2nd edge is dropped, on the 3rd accepted
    reset = 1'b1;
    tick(1);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    tick(1);
    chk("sync_edge2_busy", {31'd0, bus.busy}, 32'd0);
    tick(1);
    bus.start = 1'b0;
    chk("sync_edge3_busy", {31'd0, bus.busy}, 32'd1);
    run_until_done(en_cnt, rst_cnt);
    chk("post_rst_cnt", rst_cnt, 32'd2);
    chk("post_en_cnt",  en_cnt,  32'd80);
    chk("post_status",  {30'd0, bus.status}, 32'd2);
    chk("post_cycles",  {16'd0, bus.cycles}, 32'd80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
